// File: rtl/decoder_scan_seq.sv
// Scan sequencer for a 3-to-8 decoder: drives E/In so the one-hot output
// walks codes 0..7, each held dwell+1 cycles, single-pass or continuous.
module decoder_scan_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clka,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               E,
  output logic [2:0]         In,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t             r_state, w_state_nx;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nx;
  logic [DWELL_W-1:0] r_dwell_lat, w_dwell_nx;
  logic               r_mode_lat, w_mode_nx;
  logic [2:0]         r_in, w_in_nx;
  logic               r_e, r_busy, r_done, w_done_nx;

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_dwell_nx = r_dwell_lat;
    w_mode_nx  = r_mode_lat;
    w_in_nx    = r_in;
    w_done_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_nx = 3'd0;
        if (start && !stop) begin
          w_state_nx = ST_SCAN;
          w_cnt_nx   = {DWELL_W{1'b0}};
          w_dwell_nx = dwell;
          w_mode_nx  = mode;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (stop) begin
          w_state_nx = ST_IDLE;
          w_in_nx    = 3'd0;
          w_cnt_nx   = {DWELL_W{1'b0}};
        end else if (hold) begin
          w_state_nx = ST_SCAN;
        end else if (r_cnt < r_dwell_lat) begin
          w_cnt_nx = r_cnt + {{(DWELL_W-1){1'b0}}, 1'b1};
        end else begin
          w_cnt_nx = {DWELL_W{1'b0}};
          if (r_in != 3'd7) begin
            w_in_nx = r_in + 3'd1;
          end else if (r_mode_lat) begin
            w_in_nx = 3'd0;
          end else begin
            w_state_nx = ST_IDLE;
            w_in_nx    = 3'd0;
            w_done_nx  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_in_nx    = 3'd0;
        w_cnt_nx   = {DWELL_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {DWELL_W{1'b0}};
      r_dwell_lat <= {DWELL_W{1'b0}};
      r_mode_lat  <= 1'b0;
      r_in        <= 3'd0;
      r_e         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_dwell_lat <= w_dwell_nx;
      r_mode_lat  <= w_mode_nx;
      r_in        <= w_in_nx;
      r_e         <= (w_state_nx == ST_SCAN);
      r_busy      <= (w_state_nx == ST_SCAN);
      r_done      <= w_done_nx;
    end
  end

  assign E    = r_e;
  assign In   = r_in;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed bench for decoder_scan_seq with hand-computed expectations.
module tb_decoder_scan_seq;

  logic       clka = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, hold = 1'b0, mode = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic       E, busy, done;
  logic [2:0] In;
  int         n_total = 0, n_pass = 0;

  decoder_scan_seq #(.DWELL_W(8)) dut (
    .clka(clka), .rst(rst), .start(start), .stop(stop), .hold(hold),
    .mode(mode), .dwell(dwell), .E(E), .In(In), .busy(busy), .done(done)
  );

  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_E"}, {31'd0, E}, 32'd0);
    check({tag, "_In"}, {29'd0, In}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int e_cnt, in4_cnt, h;
    logic seen_done;

    // Reset state
    #12;
    check_idle("rst");
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick();

    // Single pass, dwell 0
    dwell = 8'd0; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("sp_In", {29'd0, In}, i);
      check("sp_E", {31'd0, E}, 32'd1);
      check("sp_busy", {31'd0, busy}, 32'd1);
      check("sp_done", {31'd0, done}, 32'd0);
      tick();
    end
    check_idle("sp_end");
    check("sp_done_pulse", {31'd0, done}, 32'd1);
    start = 1'b1;  // restart in the done cycle
    tick();
    start = 1'b0;
    check("rs_E", {31'd0, E}, 32'd1);
    check("rs_In", {29'd0, In}, 32'd0);
    check("rs_done", {31'd0, done}, 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("rs_stop");

    // Continuous, dwell 2, stop during In=3
    dwell = 8'd2; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 33; k++) begin
      check("cont_In", {29'd0, In}, (k / 3) % 8);
      check("cont_E", {31'd0, E}, 32'd1);
      check("cont_done", {31'd0, done}, 32'd0);
      tick();
    end
    check("cont_In3", {29'd0, In}, 32'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("cont_stop");
    check("cont_stop_done", {31'd0, done}, 32'd0);

    // Hold 5 cycles during In=4, dwell 1
    dwell = 8'd1; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    e_cnt = 0; in4_cnt = 0; h = 0; seen_done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!E) begin
        seen_done = done;
        break;
      end
      e_cnt++;
      if (In == 3'd4) in4_cnt++;
      if (In == 3'd4 && h < 5) begin
        hold = 1'b1;
        h++;
      end else begin
        hold = 1'b0;
      end
      tick();
    end
    hold = 1'b0;
    check("hold_Ecycles", e_cnt, 32'd21);
    check("hold_In4cycles", in4_cnt, 32'd7);
    check("hold_done", {31'd0, seen_done}, 32'd1);
    tick();

    // Mid-scan changes to dwell/mode/start ignored
    dwell = 8'd0; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    dwell = 8'd3; mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ign_In", {29'd0, In}, i);
      check("ign_E", {31'd0, E}, 32'd1);
      start = (i == 2) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    check_idle("ign_end");
    check("ign_done", {31'd0, done}, 32'd1);
    tick();

    // Asynchronous reset mid-scan at In=5
    dwell = 8'd0; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("ar_In5", {29'd0, In}, 32'd5);
    #2 rst = 1'b1;
    #1;
    check_idle("ar_async");
    check("ar_done", {31'd0, done}, 32'd0);
    #1 rst = 1'b0;
    tick();
    check_idle("ar_post");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ar_restart_E", {31'd0, E}, 32'd1);
    check("ar_restart_In", {29'd0, In}, 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // start and stop together stay idle, then start alone
    start = 1'b1; stop = 1'b1;
    tick();
    check_idle("ss_both");
    stop = 1'b0;
    tick();
    start = 1'b0;
    check("ss_E", {31'd0, E}, 32'd1);
    check("ss_busy", {31'd0, busy}, 32'd1);
    check("ss_In", {29'd0, In}, 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // dwell all-ones: 256 cycles per code
    dwell = 8'hFF; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    e_cnt = 0;
    for (int c = 0; c < 256; c++) begin
      if (In == 3'd0 && E) e_cnt++;
      tick();
    end
    check("max_code0_cycles", e_cnt, 32'd256);
    check("max_In1", {29'd0, In}, 32'd1);
    check("max_E", {31'd0, E}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("max_stop");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decoder_scan_seq.md
Name: decoder_scan_seq

Overview:
- Upstream sequencer for the 3-to-8 decoder (decoder_3_8).
- Generates the decoder's enable (E) and 3-bit select (In) so that the one-hot output scans codes 0..7.
- Each code is held for a programmable dwell time.
- Supports single-pass and continuous scanning, pause (hold) and abort (stop). Signals completion with a one-cycle done pulse.

Parameters:
- DWELL_W, 8: width of the dwell input and of the internal dwell counter. Each code is held dwell+1 cycles.

Ports:
- clka  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  begin a scan; sampled only in IDLE.
- stop  input  1  abort a scan; sampled in SCAN.
- hold  input  1  pause the scan; In and dwell counter freeze while high.
- mode  input  1  0 = single pass (0..7 then stop), 1 = continuous (wrap 7->0).
- dwell  input  DWELL_W  hold time per code, minus one; latched at start.
- E  output  1  decoder enable; high only while scanning.
- In  output  3  decoder select code.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse on single-pass completion.

Behaviour:
- Reset (async, any time, including mid-scan):
  - state = IDLE; E = 0, In = 3'b000, busy = 0, done = 0.
  - Dwell counter and latched dwell/mode cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- State IDLE:
  - E = 0, busy = 0, In = 0.
  - start = 1 and stop = 0 at an edge: enter SCAN on that edge. Outputs after the edge are E = 1, busy = 1, In = 0. dwell and mode are latched; the dwell counter is cleared.
  - start and stop both high: stay in IDLE.
  - done is high only in the first IDLE cycle after a single-pass completion, and is 0 otherwise.
- State SCAN (E = 1, busy = 1), priority stop > hold > advance:
  - stop = 1: go to IDLE on the next edge (E = 0, In = 0). No done pulse.
  - hold = 1: In and the dwell counter keep their values; E stays 1.
  - Otherwise, if cnt < dwell_lat: cnt increments.
  - Otherwise (cnt == dwell_lat): cnt = 0, then:
    - In < 7: In = In + 1.
    - In == 7, mode_lat = 1: In wraps to 0 and scanning continues indefinitely.
    - In == 7, mode_lat = 0: go to IDLE with E = 0, In = 0, done = 1 for exactly one cycle.
- start asserted while in SCAN is ignored.
- Changes to dwell or mode during SCAN have no effect until the next start.
- Timing for dwell = D with no hold or stop:
  - Each code is visible for exactly D+1 cycles.
  - E is high for 8(D+1) consecutive cycles in single mode.
  - done rises on the edge after the last In = 7 cycle.
- dwell = 0 is legal: In advances every cycle.
- dwell = all-ones is legal: 2^DWELL_W cycles per code, with no counter overflow.
- start can be re-asserted in the same cycle done is high: the FSM is in IDLE then, so it re-enters SCAN on the next edge.

Test Plan:
- Reset, then start with dwell = 0, mode = 0 -> E = 1 for 8 cycles, In = 0,1,…,7 one per cycle, then E = 0, In = 0, done = 1 for exactly 1 cycle, busy falls with E.
- start with dwell = 2, mode = 1 -> each In held 3 cycles, sequence 0..7,0,1… wraps with no done pulse. Asserting stop during In = 3 -> next cycle E = 0, In = 0, busy = 0, done = 0.
- dwell = 1, hold asserted 5 cycles while In = 4 -> In stays 4 and E stays 1 for 5 extra cycles, then the scan resumes with the remaining dwell count; total E-high time = 16 + 5 cycles.
- Change dwell from 0 to 3 and mode from 0 to 1 mid-scan, and pulse start mid-scan -> no change: still 1 cycle per code, a single pass, and done after In = 7.
- Assert rst asynchronously (between clock edges) while In = 5 -> E, busy, done and In go to 0 immediately without waiting for an edge. After release, start behaves as from power-up.
- In IDLE, start and stop high together -> stays IDLE, E = 0. Then start alone -> SCAN begins with In = 0 on that edge.
